// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the buffered debug UART transmitter.
package debug_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;

  function automatic int calc_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int calc_cnt_w(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// Small synchronous byte FIFO; the extra level bit separates full from empty.
module debug_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;
  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Buffered 8N1 debug UART transmitter: CPU byte writes queue in a FIFO and are serialised.
// Define DEBUG_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module debug_uart_tx_fifo
  import debug_uart_pkg::*;
#(
  parameter int CLK_HZ     = 64_000_000,
  parameter int BIT_RATE   = 4_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          ovf_clr,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int CW  = calc_cnt_w(CPB);

  uart_state_t state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          ovf_reg;
  logic          at_bound;
  logic          pop;
  logic [7:0]    pop_data;
  logic          fifo_empty;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  debug_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign at_bound = (baud_reg == CW'(CPB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      txd_reg    <= 1'b1;
      ovf_reg    <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      txd_reg    <= txd_next;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
      // A write landing on a full FIFO beats a simultaneous clear.
      if (wr_en && fifo_full) ovf_reg <= 1'b1;
      else if (ovf_clr)       ovf_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    pop         = 1'b0;
    txd_next    = 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    if (state_reg != IDLE) baud_next = at_bound ? '0 : baud_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = pop_data;
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (at_bound) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (at_bound) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
`ifdef DEBUG_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (at_bound) state_next = STOP;
      end
      STOP: begin
        // Reload straight into START so back-to-back frames carry no idle gap.
        if (at_bound) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = pop_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef DEBUG_UART_TX_PARITY_EN
    if (pop) parity_next = ^pop_data;
`endif

    // txd is registered from the next state so the pin never glitches.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef DEBUG_UART_TX_PARITY_EN
      PARITY:  txd_next = parity_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  assign txd      = txd_reg;
  assign overflow = ovf_reg;
  assign tx_busy  = (state_reg != IDLE) || (fifo_level != '0);

endmodule
